// File: rtl/alu_dispatch_if.sv
// Request, ALU-side and response signal bundle for the ALU issue front-end.
interface alu_dispatch_if #(
    parameter int unsigned WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_x;
    logic [WIDTH-1:0] req_y;
    logic             alu_start;
    logic [1:0]       alu_s;
    logic [WIDTH-1:0] alu_inbus;
    logic             alu_finish;
    logic [WIDTH-1:0] alu_outbus;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_hi;
    logic [WIDTH-1:0] rsp_lo;
    logic             rsp_err;

    // Dispatcher side
    modport slave (
        input  req_valid, req_op, req_x, req_y, alu_finish, alu_outbus, rsp_ready,
        output req_ready, alu_start, alu_s, alu_inbus, rsp_valid, rsp_hi, rsp_lo, rsp_err
    );

    // Requester / ALU / consumer side
    modport master (
        output req_valid, req_op, req_x, req_y, alu_finish, alu_outbus, rsp_ready,
        input  req_ready, alu_start, alu_s, alu_inbus, rsp_valid, rsp_hi, rsp_lo, rsp_err
    );
endinterface

// File: rtl/alu_dispatch.sv
// ALU issue front-end: accepts one request, launches the ALU, serialises operands,
// collects one or two result words and returns them with an error flag.
module alu_dispatch #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic         clk,
    input  logic         rst_b,
    alu_dispatch_if.slave bus,
    output logic         busy
);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE, START, OPA, OPB, WAIT, CAP2, RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_y;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req_ready;
    logic              r_busy;
    logic              r_alu_start;
    logic [1:0]        r_alu_s;
    logic [WIDTH-1:0]  r_alu_inbus;
    logic              r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_hi;
    logic [WIDTH-1:0]  r_rsp_lo;
    logic              r_rsp_err;
    logic              w_accept;
    logic              w_div0;

    assign w_accept = (r_state == IDLE) && bus.req_valid && r_req_ready;
    assign w_div0   = (bus.req_op == 2'b11) && (bus.req_y == '0);

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; finish has priority over the watchdog expiry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_div0 ? RESP : START;
            START:   w_state_nxt = OPA;
            OPA:     w_state_nxt = OPB;
            OPB:     w_state_nxt = WAIT;
            WAIT: begin
                if (bus.alu_finish)         w_state_nxt = r_alu_s[1] ? CAP2 : RESP;
                else if (r_cnt >= TMO_LAST) w_state_nxt = RESP;
            end
            CAP2:    w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered outputs decoded from the upcoming state, plus operand/result latches
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_alu_start <= 1'b0;
            r_alu_s     <= 2'b00;
            r_alu_inbus <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_hi    <= '0;
            r_rsp_lo    <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE);
            r_alu_start <= (w_state_nxt == START);
            r_rsp_valid <= (w_state_nxt == RESP);

            if (w_state_nxt == OPA)      r_alu_inbus <= r_x;
            else if (w_state_nxt == OPB) r_alu_inbus <= r_y;
            else                         r_alu_inbus <= '0;

            // Watchdog: zero outside WAIT, counts and saturates inside it
            if (r_state != WAIT)     r_cnt <= '0;
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);

            if (w_accept) begin
                r_x       <= bus.req_x;
                r_y       <= bus.req_y;
                r_rsp_hi  <= '0;
                r_rsp_lo  <= '0;
                r_rsp_err <= w_div0;
                if (!w_div0) r_alu_s <= bus.req_op;
            end else if (w_state_nxt == IDLE) begin
                r_alu_s <= 2'b00;
            end

            if (r_state == WAIT) begin
                if (bus.alu_finish) begin
                    if (r_alu_s[1]) begin
                        r_rsp_hi <= bus.alu_outbus;
                    end else begin
                        r_rsp_hi <= '0;
                        r_rsp_lo <= bus.alu_outbus;
                    end
                end else if (r_cnt >= TMO_LAST) begin
                    r_rsp_err <= 1'b1;
                    r_rsp_hi  <= '0;
                    r_rsp_lo  <= '0;
                end
            end

            if (r_state == CAP2) r_rsp_lo <= bus.alu_outbus;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.alu_start = r_alu_start;
    assign bus.alu_s     = r_alu_s;
    assign bus.alu_inbus = r_alu_inbus;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_hi    = r_rsp_hi;
    assign bus.rsp_lo    = r_rsp_lo;
    assign bus.rsp_err   = r_rsp_err;
    assign busy          = r_busy;
endmodule

// File: tb/tb_alu_dispatch.sv
// Randomised self-checking bench for alu_dispatch with a behavioural ALU and reference model.
module tb_alu_dispatch;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_b;
    logic busy;

    int n_total = 0;
    int n_bad   = 0;
    int n_start = 0;

    // Shared between the request driver and the ALU model
    bit          alu_hang  = 1'b0;
    int unsigned alu_delay = 0;
    logic [1:0]  cur_op;
    logic [15:0] cur_x;
    logic [15:0] cur_y;

    alu_dispatch_if #(.WIDTH(WIDTH)) bus ();

    alu_dispatch #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Expected response {err, hi, lo} straight from the arithmetic meaning of each opcode
    function automatic logic [32:0] ref_rsp(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        case (op)
            2'b00:   return {1'b0, 16'h0, 16'(x + y)};
            2'b01:   return {1'b0, 16'h0, 16'(x - y)};
            2'b10: begin
                p = 32'(x) * 32'(y);
                return {1'b0, p};
            end
            default: begin
                if (y == 16'h0) return {1'b1, 32'h0};
                return {1'b0, 16'(x % y), 16'(x / y)};
            end
        endcase
    endfunction

    // Words the ALU places on its output bus: finish cycle, then the following cycle
    function automatic logic [31:0] alu_words(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        case (op)
            2'b00:   return {16'(a + b), 16'hDEAD};
            2'b01:   return {16'(a - b), 16'hDEAD};
            2'b10: begin
                p = 32'(a) * 32'(b);
                return p;
            end
            default: begin
                if (b == 16'h0) return 32'hFFFF_FFFF;
                return {16'(a % b), 16'(a / b)};
            end
        endcase
    endfunction

    // Count start pulses
    always @(negedge clk) if (bus.alu_start) n_start++;

    // Behavioural ALU: take operands from the bus, finish after alu_delay extra WAIT cycles
    initial begin
        logic [1:0]  op;
        logic [15:0] a, b;
        logic [31:0] w;
        bus.alu_finish = 1'b0;
        bus.alu_outbus = 16'h0;
        forever begin
            @(negedge clk);
            if (bus.alu_start) begin
                op = bus.alu_s;
                check("alu_s_start", 32'(op), 32'(cur_op));
                @(negedge clk);
                a = bus.alu_inbus;
                check("inbus_x", 32'(a), 32'(cur_x));
                @(negedge clk);
                b = bus.alu_inbus;
                check("inbus_y", 32'(b), 32'(cur_y));
                if (!alu_hang) begin
                    @(negedge clk);
                    repeat (alu_delay) @(negedge clk);
                    w = alu_words(op, a, b);
                    check("alu_s_hold", 32'(bus.alu_s), 32'(cur_op));
                    bus.alu_finish = 1'b1;
                    bus.alu_outbus = w[31:16];
                    @(negedge clk);
                    bus.alu_finish = 1'b0;
                    bus.alu_outbus = w[15:0];
                    @(negedge clk);
                    bus.alu_outbus = 16'h0;
                end
            end
        end
    end

    // One full request/response transaction with optional response backpressure
    task automatic run_req(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                           input int unsigned d, input int unsigned bp, input bit hang);
        logic [32:0] e;
        bit          div0;
        int          cyc;
        int          exp_cyc;
        int          starts0;
        div0 = (op == 2'b11) && (y == 16'h0);
        e    = hang ? {1'b1, 32'h0} : ref_rsp(op, x, y);
        if (div0)                exp_cyc = 1;
        else if (hang)           exp_cyc = 4 + int'(TIMEOUT);
        else if (op[1])          exp_cyc = 6 + int'(d);
        else                     exp_cyc = 5 + int'(d);
        alu_hang  = hang;
        alu_delay = d;
        cur_op = op; cur_x = x; cur_y = y;

        cyc = 0;
        while (!bus.req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);

        starts0 = n_start;
        bus.req_valid = 1'b1;
        bus.req_op = op; bus.req_x = x; bus.req_y = y;
        @(negedge clk);
        bus.req_valid = 1'b0;
        cyc = 1;
        while (!bus.rsp_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("latency", 32'(cyc), 32'(exp_cyc));
        check("rsp_err", 32'(bus.rsp_err), 32'(e[32]));
        check("rsp_hi", 32'(bus.rsp_hi), 32'(e[31:16]));
        check("rsp_lo", 32'(bus.rsp_lo), 32'(e[15:0]));
        check("start_cnt", 32'(n_start - starts0), div0 ? 32'd0 : 32'd1);
        check("alu_s_resp", 32'(bus.alu_s), div0 ? 32'd0 : 32'(op));

        repeat (bp) begin
            bus.req_valid = 1'b1;
            bus.req_op = 2'($urandom_range(0, 3));
            bus.req_x = 16'($urandom);
            bus.req_y = 16'($urandom);
            @(negedge clk);
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_hi", 32'(bus.rsp_hi), 32'(e[31:16]));
            check("bp_lo", 32'(bus.rsp_lo), 32'(e[15:0]));
            check("bp_err", 32'(bus.rsp_err), 32'(e[32]));
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_req_ready", 32'(bus.req_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_x     = 16'h0;
        bus.req_y     = 16'h0;
        bus.rsp_ready = 1'b0;
        cur_op = 2'b00; cur_x = 16'h0; cur_y = 16'h0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_start", 32'(bus.alu_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_inbus", 32'(bus.alu_inbus), 32'd0);

        // Directed cases
        run_req(2'b00, 16'h1234, 16'h0FED, 2, 0, 1'b0);
        run_req(2'b10, 16'h0100, 16'h0300, 1, 0, 1'b0);
        run_req(2'b11, 16'h0064, 16'h0000, 0, 0, 1'b0);
        run_req(2'b11, 16'h0064, 16'h0007, 0, 0, 1'b1);
        run_req(2'b11, 16'h0064, 16'h0007, 0, 0, 1'b0);
        run_req(2'b00, 16'hFFFF, 16'h0002, 0, 10, 1'b0);

        // Reset asserted while a MUL sits in WAIT
        alu_hang = 1'b1;
        cur_op = 2'b10; cur_x = 16'h1234; cur_y = 16'h0056;
        bus.req_valid = 1'b1;
        bus.req_op = 2'b10; bus.req_x = 16'h1234; bus.req_y = 16'h0056;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_b = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_alu_s", 32'(bus.alu_s), 32'd0);
        check("arst_inbus", 32'(bus.alu_inbus), 32'd0);
        check("arst_start", 32'(bus.alu_start), 32'd0);
        check("arst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_hi[14:0], bus.rsp_lo[14:0]}, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("arst_no_restart", 32'(bus.alu_start), 32'd0);
        run_req(2'b01, 16'h0005, 16'h0007, 0, 1, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 30; i++) begin
            logic [1:0]  op;
            logic [15:0] x, y;
            op = 2'($urandom_range(0, 3));
            x  = 16'($urandom);
            y  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            run_req(op, x, y, $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Issue front-end that sits directly upstream of the 16-bit ALU (ALU control unit plus datapath).
- Accepts one ALU request at a time over a valid/ready handshake and latches the opcode and two 16-bit operands.
- Launches the ALU with a one-cycle start pulse, serialises the operands onto the ALU input bus, and waits for finish.
- Captures one or two result words from the ALU output bus and returns them over a valid/ready response handshake with an error flag.

Parameters:
- WIDTH, 16, operand/result word width; must match the ALU.
- TIMEOUT, 64, maximum cycles in WAIT before the operation is aborted with error.
- CNT_W, 7, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  dispatcher can accept a request
- req_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- req_x  in  WIDTH  first operand (multiplicand / dividend)
- req_y  in  WIDTH  second operand (multiplier / divisor)
- alu_start  out  1  one-cycle start pulse to the ALU control unit
- alu_s  out  2  opcode to the ALU control unit, held stable for the whole operation
- alu_inbus  out  WIDTH  operand bus to the ALU datapath
- alu_finish  in  1  ALU finish strobe
- alu_outbus  in  WIDTH  ALU result bus
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_hi  out  WIDTH  MUL high word / DIV remainder; 0 for ADD/SUB
- rsp_lo  out  WIDTH  ADD/SUB result, MUL low word, DIV quotient
- rsp_err  out  1  divide-by-zero or watchdog timeout
- busy  out  1  high in any state other than IDLE

Behaviour:
- Interface decision: one clock domain, clk; reset rst_b is asynchronous and active-low.
- Reset values: state IDLE; alu_start=0, alu_s=0, alu_inbus=0, rsp_valid=0, rsp_hi=0, rsp_lo=0, rsp_err=0, busy=0; req_ready=1 once reset is released.
- Moore machine: all outputs decode from registered state and registered latches only; no combinational path from any input to any output.
- States: IDLE, START, OPA, OPB, WAIT, CAP2, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch op/x/y.
  - If op=11 and y=0: go RESP with rsp_err=1, rsp_hi=0, rsp_lo=0. No ALU start is issued.
  - Otherwise go START.
- START: alu_start=1 for exactly this cycle. alu_s=op from this cycle until the state returns to IDLE.
- OPA: alu_inbus=x for one cycle. OPB: alu_inbus=y for one cycle. alu_inbus=0 in all other states.
- WAIT:
  - Watchdog counts cycles spent in WAIT.
  - On alu_finish: capture alu_outbus. For ADD/SUB, into rsp_lo (rsp_hi=0), then go RESP. For MUL/DIV, into rsp_hi, then go CAP2.
  - If TIMEOUT cycles elapse without finish: go RESP with rsp_err=1 and the result words cleared.
  - Finish in the same cycle the counter reaches TIMEOUT: finish wins.
- CAP2: unconditionally capture alu_outbus into rsp_lo (the ALU presents the second word on the cycle after finish), then go RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_ready go IDLE.
  - rsp_ready while rsp_valid=0 is ignored.
- alu_finish outside WAIT is ignored and raises no error.
- Minimum request-to-response latency: ADD = 4 cycles + ALU time; MUL/DIV add one more cycle for CAP2.
- Back-to-back requests: no new request is accepted until the cycle after the response handshake.
- The watchdog counter is cleared on entry to WAIT and saturates; it never wraps.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A pending alu_start is never re-issued.

Test Plan:
- ADD x=0x1234, y=0x0FED; ALU model finishes after 3 cycles with 0x2221 -> exactly one alu_start pulse; alu_inbus shows 0x1234 then 0x0FED; rsp_lo=0x2221, rsp_hi=0, rsp_err=0.
- MUL x=0x0100, y=0x0300; model returns 0x0003 on the finish cycle, then 0x0000 -> rsp_hi=0x0003, rsp_lo=0x0000; alu_s=10 throughout.
- DIV x=0x0064, y=0x0000 -> no alu_start; rsp_valid one cycle after accept; rsp_err=1; rsp_hi=rsp_lo=0.
- DIV x=0x0064, y=0x0007 with the model never finishing -> rsp_err=1 exactly TIMEOUT(64) cycles after entering WAIT; a second request afterwards completes normally.
- Response backpressure: rsp_ready low for 10 cycles -> rsp_valid and data stable; req_ready=0 and req_valid ignored; accept occurs the cycle after rsp_ready.
- rst_b pulsed low during WAIT of a MUL -> all outputs at reset values asynchronously; after release, a SUB 0x0005-0x0007 returns rsp_lo=0xFFFE.
